aes_job_sequencer: RTL and testbench

Job-level sequencer for the byte-serial masked AES core. It buffers one 16-byte shared plaintext/key job from an upstream valid/ready stream and holds the core in reset until the job is complete. It then feeds the bytes at the core's fixed load rate, catches the unstallable 16-cycle ciphertext burst, and replays it downstream under valid/ready. The block sits between the system bus adapter and the core's `rst`/data/`Done` pins.

---
 rtl/aes_job_sequencer.sv | 150 +++++++++++++++
 tb/tb_aes_job_sequencer.sv | 373 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_job_sequencer.sv
// Job sequencer for the byte-serial masked AES core: buffers a 16-byte shared job,
// loads it into the core at the fixed rate, captures the ciphertext burst and replays it.
module aes_job_sequencer #(
  parameter int SHARES  = 2,
  parameter int TIMEOUT = 300
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic [8*SHARES-1:0] s_pt,
  input  logic [8*SHARES-1:0] s_key,
  output logic                core_rst,
  output logic [8*SHARES-1:0] core_pt,
  output logic [8*SHARES-1:0] core_key,
  input  logic                core_done,
  input  logic [8*SHARES-1:0] core_ct,
  output logic                m_valid,
  input  logic                m_ready,
  output logic [8*SHARES-1:0] m_ct,
  output logic                m_last,
  output logic                busy,
  output logic                err
);
  localparam int W  = 8 * SHARES;
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, LOAD, RUN, CAPTURE, DRAIN} state_e;

  state_e        state_q, state_d;
  logic [4:0]    in_cnt_q, in_cnt_d;
  logic [3:0]    idx_q, idx_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          err_q, err_d;

  // Buffers hold whole share vectors; shares are never recombined here.
  logic [W-1:0] in_pt_mem  [16];
  logic [W-1:0] in_key_mem [16];
  logic [W-1:0] out_mem    [16];

  logic s_fire;
  logic out_we;

  assign s_ready = (in_cnt_q < 5'd16) && (state_q != LOAD);
  assign s_fire  = s_valid && s_ready;
  assign busy    = (state_q != IDLE);
  assign err     = err_q;

  always_ff @(posedge clk) begin
    if (s_fire) begin
      in_pt_mem[in_cnt_q[3:0]]  <= s_pt;
      in_key_mem[in_cnt_q[3:0]] <= s_key;
    end
    if (out_we) begin
      out_mem[idx_q] <= core_ct;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      in_cnt_q <= '0;
      idx_q    <= '0;
      tmo_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      in_cnt_q <= in_cnt_d;
      idx_q    <= idx_d;
      tmo_q    <= tmo_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    in_cnt_d = in_cnt_q;
    idx_d    = idx_q;
    tmo_d    = tmo_q;
    err_d    = err_q;
    out_we   = 1'b0;
    core_rst = 1'b1;
    core_pt  = '0;
    core_key = '0;
    m_valid  = 1'b0;
    m_last   = 1'b0;
    m_ct     = '0;

    if (s_fire) begin
      in_cnt_d = in_cnt_q + 5'd1;
    end

    case (state_q)
      IDLE: begin
        if (in_cnt_q == 5'd16) begin
          state_d = LOAD;
          idx_d   = '0;
        end
      end
      LOAD: begin
        // The core latches byte 0 during its final reset cycle.
        core_rst = (idx_q == 4'd0);
        core_pt  = in_pt_mem[idx_q];
        core_key = in_key_mem[idx_q];
        idx_d    = idx_q + 4'd1;
        if (idx_q == 4'd15) begin
          in_cnt_d = '0;
          tmo_d    = '0;
          state_d  = RUN;
        end
      end
      RUN: begin
        core_rst = 1'b0;
        tmo_d    = tmo_q + TW'(1);
        // idx is 0 throughout RUN, so the first ciphertext byte lands in slot 0.
        if (core_done) begin
          out_we  = 1'b1;
          idx_d   = 4'd1;
          state_d = CAPTURE;
        end else if (tmo_q == TW'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end
      CAPTURE: begin
        core_rst = 1'b0;
        out_we   = 1'b1;
        if (!core_done) begin
          err_d = 1'b1;
        end
        idx_d = idx_q + 4'd1;
        if (idx_q == 4'd15) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        m_valid = 1'b1;
        m_ct    = out_mem[idx_q];
        m_last  = (idx_q == 4'd15);
        if (m_ready) begin
          idx_d = idx_q + 4'd1;
          if (idx_q == 4'd15) begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_aes_job_sequencer.sv
// Scoreboard bench: a behavioural masked AES core model feeds the sequencer and a
// monitor checks every output beat against the core's emitted shares and a reference AES.
module tb_aes_job_sequencer;
  localparam int SHARES  = 2;
  localparam int TIMEOUT = 300;
  localparam int W       = 8 * SHARES;

  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

  logic         clk = 1'b0;
  logic         rst;
  logic         s_valid, s_ready;
  logic [W-1:0] s_pt, s_key;
  logic         core_rst, core_done;
  logic [W-1:0] core_pt, core_key, core_ct;
  logic         m_valid, m_ready, m_last, busy, err;
  logic [W-1:0] m_ct;

  aes_job_sequencer #(.SHARES(SHARES), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready), .s_pt(s_pt), .s_key(s_key),
    .core_rst(core_rst), .core_pt(core_pt), .core_key(core_key),
    .core_done(core_done), .core_ct(core_ct),
    .m_valid(m_valid), .m_ready(m_ready), .m_ct(m_ct), .m_last(m_last),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;
  int drained = 0;
  int beat_n = 0;
  int ready_mode = 0;
  int lat_force = 0;
  bit core_mute = 1'b0;
  logic [7:0]   exp_q[$];
  logic [W-1:0] ct_q[$];
  logic [W-1:0] jp[2][16];
  logic [W-1:0] jk[2][16];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [7:0] sb(input logic [7:0] x);
    return SBOX[2047 - 8*int'(x) -: 8];
  endfunction

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Plain AES-128 encryption; byte 0 is the most significant byte.
  function automatic logic [127:0] aes128(input logic [127:0] pt, input logic [127:0] key);
    logic [7:0] s[16];
    logic [7:0] k[16];
    logic [7:0] t[16];
    logic [7:0] rc, a0, a1, a2, a3, w0, w1, w2, w3;
    logic [127:0] res;
    rc = 8'h01;
    for (int i = 0; i < 16; i++) begin
      k[i] = key[127-8*i -: 8];
      s[i] = pt[127-8*i -: 8] ^ k[i];
    end
    for (int r = 1; r <= 10; r++) begin
      w0 = sb(k[13]) ^ rc; w1 = sb(k[14]); w2 = sb(k[15]); w3 = sb(k[12]);
      k[0] ^= w0; k[1] ^= w1; k[2] ^= w2; k[3] ^= w3;
      for (int i = 4; i < 16; i++) k[i] ^= k[i-4];
      rc = xt(rc);
      for (int c = 0; c < 4; c++)
        for (int rr = 0; rr < 4; rr++) t[4*c+rr] = sb(s[4*((c+rr)%4)+rr]);
      for (int c = 0; c < 4; c++) begin
        a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
        if (r != 10) begin
          s[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
          s[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
          s[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
          s[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
        end else begin
          s[4*c] = a0; s[4*c+1] = a1; s[4*c+2] = a2; s[4*c+3] = a3;
        end
      end
      for (int i = 0; i < 16; i++) s[i] ^= k[i];
    end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
    return res;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Core model: samples byte 0 in the last reset cycle, bytes 1..15 after,
  // then after a latency emits 16 freshly masked ciphertext bytes.
  int ld_n = 16, wait_n = 0, emit_n = 16;
  bit loaded = 1'b0, mute_job = 1'b0;
  logic [W-1:0] cp[16], ck[16];
  logic [127:0] cpt, ckey, cres;
  logic [7:0] cr, cb;
  initial begin
    core_done = 1'b0;
    core_ct   = '0;
    forever begin
      step();
      core_done = 1'b0;
      core_ct   = '0;
      if (core_rst) begin
        ld_n = 0; cp[0] = core_pt; ck[0] = core_key; loaded = 1'b0; emit_n = 16;
      end else if (ld_n < 15) begin
        ld_n++;
        cp[ld_n] = core_pt;
        ck[ld_n] = core_key;
        if (ld_n == 15) begin
          for (int i = 0; i < 16; i++) begin
            cpt[127-8*i -: 8]  = cp[i][15:8] ^ cp[i][7:0];
            ckey[127-8*i -: 8] = ck[i][15:8] ^ ck[i][7:0];
          end
          cres = aes128(cpt, ckey);
          loaded = 1'b1; emit_n = 0; mute_job = core_mute;
          wait_n = (lat_force > 0) ? lat_force : int'($urandom_range(1, 60));
        end
      end else if (loaded && !mute_job) begin
        if (wait_n > 1) wait_n--;
        else if (emit_n < 16) begin
          cr = 8'($urandom);
          cb = cres[127-8*emit_n -: 8];
          core_ct = {cr, cb ^ cr};
          core_done = 1'b1;
          ct_q.push_back(core_ct);
          emit_n++;
        end
      end
    end
  end

  int rc_n = 0;
  initial begin
    m_ready = 1'b1;
    forever begin
      step();
      rc_n++;
      case (ready_mode)
        0:       m_ready = 1'b1;
        1:       m_ready = (rc_n % 3 == 0);
        default: m_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Scoreboard monitor: one line per output beat, plus stall stability checks.
  bit prev_stall = 1'b0;
  logic [W-1:0] prev_ct, got_ct;
  logic prev_last;
  logic [7:0] got_b;
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        beat_n = 0; prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          chk("stall_valid", m_valid, 1'b1);
          chk("stall_ct", m_ct, prev_ct);
          chk("stall_last", m_last, prev_last);
        end
        if (m_valid && m_ready) begin
          if (ct_q.size() == 0 || exp_q.size() == 0) begin
            checks++;
            $display("FAIL unexpected_beat: got m_ct %0h with no beat expected", m_ct);
          end else begin
            got_ct = ct_q.pop_front();
            got_b  = exp_q.pop_front();
            $display("beat %0d m_ct=%h last=%0d", beat_n, m_ct, m_last);
            chk("ct_shares", m_ct, got_ct);
            chk("ct_value", m_ct[15:8] ^ m_ct[7:0], got_b);
            chk("m_last", m_last, (beat_n == 15));
          end
          if (beat_n == 15) begin
            beat_n = 0; drained++;
          end else beat_n++;
        end
        prev_stall = m_valid && !m_ready;
        prev_ct    = m_ct;
        prev_last  = m_last;
      end
    end
  end

  task automatic prep_job(input int slot, input logic [127:0] pt, input logic [127:0] key,
                          input bit want, input logic [127:0] ct);
    logic [7:0] r, b;
    for (int i = 0; i < 16; i++) begin
      r = 8'($urandom); b = pt[127-8*i -: 8];  jp[slot][i] = {r, b ^ r};
      r = 8'($urandom); b = key[127-8*i -: 8]; jk[slot][i] = {r, b ^ r};
      if (want) exp_q.push_back(ct[127-8*i -: 8]);
    end
  endtask

  task automatic send_job(input int slot, input bit gaps);
    int i = 0;
    int n = 0;
    bit acc;
    step();
    while (i < 16) begin
      if (n++ > 5000) begin
        checks++;
        $display("FAIL send_timeout: got %0d beats accepted expected 16", i);
        break;
      end
      if (gaps && $urandom_range(0, 3) == 0) begin
        s_valid = 1'b0; acc = 1'b0;
      end else begin
        s_valid = 1'b1; s_pt = jp[slot][i]; s_key = jk[slot][i]; acc = s_ready;
      end
      step();
      if (acc) i++;
    end
    s_valid = 1'b0;
  endtask

  task automatic wait_busy();
    int n = 0;
    do begin step(); n++; end while (!busy && n < 3000);
    chk("wait_busy", busy, 1'b1);
  endtask

  task automatic wait_drained(input int target);
    int n = 0;
    while (drained < target && n < 5000) begin step(); n++; end
    chk("drain_count", drained, target);
  endtask

  task automatic rand_job(input int slot);
    logic [127:0] pt, key;
    pt  = {$urandom, $urandom, $urandom, $urandom};
    key = {$urandom, $urandom, $urandom, $urandom};
    prep_job(slot, pt, key, 1'b1, aes128(pt, key));
  endtask

  task automatic check_reset_outputs();
    chk("rst_s_ready", s_ready, 1'b1);
    chk("rst_m_valid", m_valid, 1'b0);
    chk("rst_m_last", m_last, 1'b0);
    chk("rst_core_rst", core_rst, 1'b1);
    chk("rst_core_pt", core_pt, '0);
    chk("rst_core_key", core_key, '0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_err", err, 1'b0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish expected finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; s_valid = 1'b0; s_pt = '0; s_key = '0;
    repeat (3) step();
    check_reset_outputs();
    rst = 1'b1;
    step();

    // FIPS-197 vector
    prep_job(0, 128'h00112233445566778899aabbccddeeff, 128'h000102030405060708090a0b0c0d0e0f,
             1'b1, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
    send_job(0, 1'b0);
    wait_drained(1);
    chk("fips_busy_after", busy, 1'b0);
    chk("fips_err", err, 1'b0);

    // Backpressure: ready one cycle in three
    ready_mode = 1;
    rand_job(1);
    send_job(1, 1'b0);
    wait_drained(2);
    chk("bp_busy_after", busy, 1'b0);
    ready_mode = 0;

    // Prefetch with s_valid held through LOAD
    rand_job(0);
    send_job(0, 1'b0);
    rand_job(1);
    fork
      send_job(1, 1'b0);
      begin
        wait_busy();
        for (int i = 0; i < 16; i++) begin
          if (i > 0) step();
          chk("load_s_ready", s_ready, 1'b0);
          chk("load_core_rst", core_rst, (i == 0));
          chk("load_core_pt", core_pt, jp[0][i]);
          chk("load_core_key", core_key, jk[0][i]);
        end
      end
    join
    chk("prefetch_full_s_ready", s_ready, 1'b0);
    wait_drained(3);
    chk("b2b_idle_busy", busy, 1'b0);
    chk("b2b_idle_core_rst", core_rst, 1'b1);
    step();
    chk("b2b_load_busy", busy, 1'b1);
    chk("b2b_load_core_rst", core_rst, 1'b1);
    step();
    chk("b2b_load1_core_rst", core_rst, 1'b0);
    wait_drained(4);

    // Timeout: core never answers
    core_mute = 1'b1;
    rand_job(0);
    exp_q.delete();
    send_job(0, 1'b0);
    wait_busy();
    repeat (16 + TIMEOUT - 1) step();
    chk("tmo_last_run_core_rst", core_rst, 1'b0);
    chk("tmo_last_run_err", err, 1'b0);
    step();
    chk("tmo_err", err, 1'b1);
    chk("tmo_core_rst", core_rst, 1'b1);
    chk("tmo_busy", busy, 1'b0);
    chk("tmo_m_valid", m_valid, 1'b0);
    core_mute = 1'b0;
    rand_job(1);
    send_job(1, 1'b0);
    wait_drained(5);
    chk("tmo_err_sticky", err, 1'b1);

    // Reset pulse at RUN cycle 100
    lat_force = 150;
    rand_job(0);
    send_job(0, 1'b0);
    wait_busy();
    repeat (116) step();
    chk("pre_rst_core_rst", core_rst, 1'b0);
    rst = 1'b0;
    #1;
    check_reset_outputs();
    step();
    rst = 1'b1;
    exp_q.delete();
    ct_q.delete();
    lat_force = 0;
    rand_job(1);
    send_job(1, 1'b0);
    wait_drained(6);
    chk("post_rst_err", err, 1'b0);

    // Random back-to-back jobs with random gaps and backpressure
    ready_mode = 2;
    for (int j = 0; j < 4; j++) begin
      rand_job(j % 2);
      send_job(j % 2, 1'b1);
    end
    wait_drained(10);
    chk("final_exp_q_empty", exp_q.size(), 0);
    chk("final_ct_q_empty", ct_q.size(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
